mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the result, load-data and writeback-data buses.
REQ-002 Parameter REG_ADDR_W, default 5, width of register-file addresses.
REQ-003 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-004 clock  input  1  single clock; all state SHALL update on the posedge only.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 valid_IN  input  1  the MEM-stage instruction is real (not a bubble).
REQ-007 memory_RD_IN  input  1  the MEM-stage instruction is a load.
REQ-008 reg_write_IN  input  1  the MEM-stage instruction writes a register.
REQ-009 address_for_register_RD_IN  input  REG_ADDR_W  destination register.
REQ-010 result_IN  input  DATA_W  ALU result of the MEM-stage instruction.
REQ-011 data_for_RD_IN  input  DATA_W  load data from the data memory (updated on negedge, stable at posedge).
REQ-012 stall_IN  input  1  hold the stage contents.
REQ-013 flush_IN  input  1  insert a bubble.
REQ-014 wb_valid_out  output  1  the stage holds a real instruction.
REQ-015 wb_we_out  output  1  register-file write strobe.
REQ-016 wb_addr_out  output  REG_ADDR_W  register-file write address.
REQ-017 wb_data_out  output  DATA_W  register-file write data.
REQ-018 retired_count_out  output  CNT_W  count of instructions retired.

Function
REQ-019 At each posedge with flush_IN=1, the stage SHALL capture a bubble: valid=0, we=0.
  - Flush SHALL override stall_IN.
REQ-020 At each posedge with flush_IN=0 and stall_IN=1, all stage registers SHALL hold their values.
  - Exception: the write-done flag (REQ-023) SHALL still update.
REQ-021 At each posedge with flush_IN=0 and stall_IN=0, the stage SHALL capture the following (latency exactly 1 cycle from the MEM-stage inputs):
  - valid_IN;
  - address_for_register_RD_IN;
  - wb_data_out = data_for_RD_IN when memory_RD_IN=1, else result_IN;
  - a write-intent bit = valid_IN & reg_write_IN & (address_for_register_RD_IN != 0).
REQ-022 The stage SHALL never assert a write to register 0.
  - Such an instruction still retires: it is counted and sets wb_valid_out.
REQ-023 wb_we_out SHALL equal write-intent & ~write_done.
  - write_done is set at the first posedge after wb_we_out=1 while the stage is stalled.
  - write_done is cleared whenever a new instruction or bubble is captured.
  - Result: each instruction writes exactly once, even across multi-cycle stalls.
REQ-024 wb_addr_out and wb_data_out SHALL be registered outputs.
  - They are valid whenever wb_valid_out=1.
  - When wb_valid_out=0 they retain their last values (no zeroing required).
REQ-025 retired_count_out SHALL increment by 1 at each posedge that captures an instruction with valid_IN=1 under REQ-021.
REQ-026 retired_count_out SHALL saturate at all-ones and never wrap.
REQ-027 Simultaneous valid_IN=1 with stall_IN=1 SHALL neither capture nor count; the upstream stage holds the instruction.
REQ-028 Simultaneous valid_IN=1 with flush_IN=1 SHALL neither capture nor count.

Reset
REQ-029 While reset_n=0, the following SHALL be forced to 0 asynchronously, regardless of clock:
  - wb_valid_out, wb_we_out, wb_addr_out, wb_data_out;
  - write-intent, write_done, retired_count_out.
REQ-030 On the first posedge after reset_n rises, the stage SHALL behave per REQ-019..REQ-021.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction; that instruction is never written.

Verification
REQ-032 ALU write: valid=1, reg_write=1, load=0, rd=5, result=0x0000_00AA.
  - After one posedge: we=1, addr=5, data=0x0000_00AA, count=1.
REQ-033 Load: load=1, result=0x7, data_for_RD_IN=0x0000_0001, rd=9.
  - Next cycle: data=0x0000_0001, addr=9, we=1.
REQ-034 Write to $zero: rd=0, reg_write=1, valid=1.
  - Next cycle: wb_valid_out=1, we=0, count increments.
REQ-035 Stall: capture rd=3, data=0x55, then hold stall_IN=1 for 3 cycles.
  - we=1 in the first cycle only, then 0; addr and data held; count unchanged.
REQ-036 Flush with stall: flush_IN=1 together with stall_IN=1 and valid_IN=1.
  - Next cycle: wb_valid_out=0, we=0, count unchanged.
REQ-037 Saturation and reset: preload count to all-ones, capture a valid instruction.
  - Count stays all-ones.
  - Assert reset_n=0 between clock edges: all outputs read 0 immediately.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: MEM-side instruction fields, pipeline control, and the
// register-file write port plus the retire counter. master = driver, slave = stage.
interface mem_wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  valid_IN;
  logic                  memory_RD_IN;
  logic                  reg_write_IN;
  logic [REG_ADDR_W-1:0] address_for_register_RD_IN;
  logic [DATA_W-1:0]     result_IN;
  logic [DATA_W-1:0]     data_for_RD_IN;
  logic                  stall_IN;
  logic                  flush_IN;

  logic                  wb_valid_out;
  logic                  wb_we_out;
  logic [REG_ADDR_W-1:0] wb_addr_out;
  logic [DATA_W-1:0]     wb_data_out;
  logic [CNT_W-1:0]      retired_count_out;

  modport master (
    output valid_IN, memory_RD_IN, reg_write_IN, address_for_register_RD_IN,
           result_IN, data_for_RD_IN, stall_IN, flush_IN,
    input  wb_valid_out, wb_we_out, wb_addr_out, wb_data_out, retired_count_out
  );

  modport slave (
    input  valid_IN, memory_RD_IN, reg_write_IN, address_for_register_RD_IN,
           result_IN, data_for_RD_IN, stall_IN, flush_IN,
    output wb_valid_out, wb_we_out, wb_addr_out, wb_data_out, retired_count_out
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: 1-cycle capture, flush beats stall, stall holds contents
// and lets the held instruction write the register file only once. Saturating retire count.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_wb_stage_if.slave mw
);

  logic                  valid_q,  valid_d;
  logic                  intent_q, intent_d;
  logic                  done_q,   done_d;
  logic [REG_ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0]     data_q,   data_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;

  always_comb begin
    valid_d  = valid_q;
    intent_d = intent_q;
    done_d   = done_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    if (mw.flush_IN) begin
      valid_d  = 1'b0;
      intent_d = 1'b0;
      done_d   = 1'b0;
    end else if (mw.stall_IN) begin
      // Once the strobe has been seen at one edge, suppress it for the rest of the stall.
      done_d = done_q | intent_q;
    end else begin
      valid_d  = mw.valid_IN;
      intent_d = mw.valid_IN & mw.reg_write_IN & (mw.address_for_register_RD_IN != '0);
      done_d   = 1'b0;
      addr_d   = mw.address_for_register_RD_IN;
      data_d   = mw.memory_RD_IN ? mw.data_for_RD_IN : mw.result_IN;
      if (mw.valid_IN && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      intent_q <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      intent_q <= intent_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mw.wb_valid_out      = valid_q;
  assign mw.wb_we_out         = intent_q & ~done_q;
  assign mw.wb_addr_out       = addr_q;
  assign mw.wb_data_out       = data_q;
  assign mw.retired_count_out = cnt_q;

endmodule
